// File: rtl/fft_agu_seq.sv
// fft_agu_seq: self-sequencing address generator for an in-place radix-2 FFT.
// Loads samples in bit-reversed order, walks every butterfly of every level,
// delays write addresses to match the butterfly latency, then streams results out.
module fft_agu_seq #(
  parameter int LOG2N  = 6,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG2N-1:0] load_addr,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] out_addr,
  output logic             out_bank,
  output logic             busy,
  output logic             done
);

  localparam int N  = 1 << LOG2N;
  localparam int LW = $clog2(LOG2N);
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [LOG2N-1:0] CNT_MAX   = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] HALF_MAX  = LOG2N'(N / 2 - 1);
  localparam logic [LW-1:0]    LEVEL_MAX = LW'(LOG2N - 1);
  localparam logic [DW-1:0]    DRAIN_MAX = DW'(BF_LAT - 1);
  localparam logic [LOG2N-2:0] TW_ONES   = '1;
  localparam logic             OUT_BANK  = 1'(LOG2N % 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROC, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DW-1:0]    drain_q, drain_d;

  logic             in_ready_q, in_ready_d;
  logic [LOG2N-1:0] load_addr_q, load_addr_d;
  logic             rd_en_q, rd_en_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [LOG2N-2:0] twiddle_addr_q, twiddle_addr_d;
  logic             out_valid_q, out_valid_d;
  logic [LOG2N-1:0] out_addr_q, out_addr_d;
  logic             out_bank_q, out_bank_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BF_LAT-1:0] dl_en_q, dl_en_d;
  logic [BF_LAT-1:0] dl_bank_q, dl_bank_d;
  logic [LOG2N-1:0]  dl_a_q [BF_LAT];
  logic [LOG2N-1:0]  dl_a_d [BF_LAT];
  logic [LOG2N-1:0]  dl_b_q [BF_LAT];
  logic [LOG2N-1:0]  dl_b_d [BF_LAT];

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // Rotate left within LOG2N bits; the doubled word makes the wrap-around fall out of a plain shift.
  function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] x, input logic [LW-1:0] k);
    logic [2*LOG2N-1:0] dbl;
    dbl = {x, x} << k;
    return dbl[2*LOG2N-1:LOG2N];
  endfunction

  // Sequencer next state, then all outputs decoded from the next state so they leave the block registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == CNT_MAX) begin
            state_d = S_PROC;
            cnt_d   = '0;
            level_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PROC: begin
        if (cnt_q == HALF_MAX) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_MAX) begin
          cnt_d = '0;
          if (level_q == LEVEL_MAX) begin
            state_d = S_OUT;
          end else begin
            state_d = S_PROC;
            level_d = level_q + 1'b1;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == CNT_MAX) state_d = S_DONE;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d     = (state_d == S_LOAD);
    load_addr_d    = in_ready_d ? bit_rev(cnt_d) : '0;
    rd_en_d        = (state_d == S_PROC);
    rd_bank_d      = rd_en_d & level_d[0];
    rd_addr_a_d    = rd_en_d ? rotl({cnt_d[LOG2N-2:0], 1'b0}, level_d) : '0;
    rd_addr_b_d    = rd_en_d ? rotl({cnt_d[LOG2N-2:0], 1'b1}, level_d) : '0;
    twiddle_addr_d = rd_en_d ? (cnt_d[LOG2N-2:0] & ~(TW_ONES >> level_d)) : '0;
    out_valid_d    = (state_d == S_OUT);
    out_addr_d     = out_valid_d ? cnt_d : '0;
    out_bank_d     = out_valid_d & OUT_BANK;
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
  end

  // Write-side delay line; results land in the bank opposite the one being read.
  always_comb begin
    dl_en_d[0]   = rd_en_q;
    dl_bank_d[0] = rd_en_q & ~rd_bank_q;
    dl_a_d[0]    = rd_addr_a_q;
    dl_b_d[0]    = rd_addr_b_q;
    for (int i = 1; i < BF_LAT; i++) begin
      dl_en_d[i]   = dl_en_q[i-1];
      dl_bank_d[i] = dl_bank_q[i-1];
      dl_a_d[i]    = dl_a_q[i-1];
      dl_b_d[i]    = dl_b_q[i-1];
    end
  end

  // All state, output and delay-line registers; reset aborts any transform and flushes pending writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      level_q        <= '0;
      drain_q        <= '0;
      in_ready_q     <= 1'b0;
      load_addr_q    <= '0;
      rd_en_q        <= 1'b0;
      rd_bank_q      <= 1'b0;
      rd_addr_a_q    <= '0;
      rd_addr_b_q    <= '0;
      twiddle_addr_q <= '0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_bank_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      dl_en_q        <= '0;
      dl_bank_q      <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a_q[i] <= '0;
        dl_b_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      level_q        <= level_d;
      drain_q        <= drain_d;
      in_ready_q     <= in_ready_d;
      load_addr_q    <= load_addr_d;
      rd_en_q        <= rd_en_d;
      rd_bank_q      <= rd_bank_d;
      rd_addr_a_q    <= rd_addr_a_d;
      rd_addr_b_q    <= rd_addr_b_d;
      twiddle_addr_q <= twiddle_addr_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_bank_q     <= out_bank_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      dl_en_q        <= dl_en_d;
      dl_bank_q      <= dl_bank_d;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a_q[i] <= dl_a_d[i];
        dl_b_q[i] <= dl_b_d[i];
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign load_addr    = load_addr_q;
  assign rd_en        = rd_en_q;
  assign rd_bank      = rd_bank_q;
  assign rd_addr_a    = rd_addr_a_q;
  assign rd_addr_b    = rd_addr_b_q;
  assign twiddle_addr = twiddle_addr_q;
  assign wr_en        = dl_en_q[BF_LAT-1];
  assign wr_bank      = dl_bank_q[BF_LAT-1];
  assign wr_addr_a    = dl_a_q[BF_LAT-1];
  assign wr_addr_b    = dl_b_q[BF_LAT-1];
  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_bank     = out_bank_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fft_agu_seq.sv
// tb_fft_agu_seq: scoreboard bench for the FFT address generator.
// Stimulus pushes expected load/read/write/output addresses; a negedge monitor pops and compares.
module tb_fft_agu_seq;

  localparam int LOG2N  = 6;
  localparam int BF_LAT = 3;
  localparam int N      = 1 << LOG2N;
  localparam int HALF   = N / 2;

  typedef struct {
    int bank;
    int a;
    int b;
    int tw;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic [LOG2N-1:0] load_addr;
  logic             rd_en;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] twiddle_addr;
  logic             wr_en;
  logic             wr_bank;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             out_valid;
  logic [LOG2N-1:0] out_addr;
  logic             out_bank;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q_rd[$];
  exp_t q_wr[$];
  int   q_load[$];
  int   q_out[$];

  int rd_seen, wr_seen, load_seen, done_seen, idle_run;
  bit chk_ready_drop;
  logic [BF_LAT-1:0] en_hist;
  logic prev_ov, prev_or;
  int   prev_oa;
  int   load_head[5] = '{0, 32, 16, 48, 8};

  always #5 clk = ~clk;

  fft_agu_seq #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .load_addr(load_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .twiddle_addr(twiddle_addr),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_bank(out_bank),
    .busy(busy), .done(done)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int bitRev(input int x);
    int r = 0;
    for (int i = 0; i < LOG2N; i++)
      if ((x & (1 << i)) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  function automatic int rotL(input int x, input int k);
    return ((x << k) | (x >> (LOG2N - k))) & (N - 1);
  endfunction

  task automatic resetScoreboard();
    q_rd.delete();
    q_wr.delete();
    q_load.delete();
    q_out.delete();
    rd_seen = 0;
    wr_seen = 0;
    load_seen = 0;
    done_seen = 0;
    idle_run = 0;
    chk_ready_drop = 0;
    en_hist = '0;
    prev_ov = 1'b0;
    prev_or = 1'b0;
    prev_oa = 0;
  endtask

  task automatic pushExpected();
    exp_t e;
    for (int i = 0; i < N; i++) q_load.push_back(bitRev(i));
    for (int k = 0; k < LOG2N; k++) begin
      for (int j = 0; j < HALF; j++) begin
        e.bank = k % 2;
        e.a    = rotL(2 * j, k);
        e.b    = rotL(2 * j + 1, k);
        e.tw   = (j >> (LOG2N - 1 - k)) << (LOG2N - 1 - k);
        q_rd.push_back(e);
        e.bank = 1 - (k % 2);
        e.tw   = 0;
        q_wr.push_back(e);
      end
    end
    for (int i = 0; i < N; i++) q_out.push_back(i);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard whenever the DUT presents a strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (chk_ready_drop) begin
          checkOutput("in_ready_drop", in_ready, 0);
          chk_ready_drop = 0;
        end
        if (in_valid && in_ready) begin
          if (load_seen < 5) checkOutput("load_head", load_addr, load_head[load_seen]);
          if (load_seen == N - 1) checkOutput("load_last", load_addr, 63);
          if (q_load.size() == 0) checkOutput("load_unexpected", 1, 0);
          else checkOutput("load_addr", load_addr, q_load.pop_front());
          load_seen++;
          if (load_seen == N) chk_ready_drop = 1;
        end

        if (rd_en) begin
          if (rd_seen > 0 && rd_seen % HALF == 0) begin
            checkOutput("drain_idle", idle_run, BF_LAT);
            checkOutput("raw_writes_done", wr_seen, rd_seen);
          end
          if (q_rd.size() == 0) checkOutput("rd_unexpected", 1, 0);
          else begin
            e = q_rd.pop_front();
            checkOutput("rd_bank", rd_bank, e.bank);
            checkOutput("rd_addr_a", rd_addr_a, e.a);
            checkOutput("rd_addr_b", rd_addr_b, e.b);
            checkOutput("twiddle", twiddle_addr, e.tw);
          end
          if (rd_seen == HALF + 3) begin
            checkOutput("l1j3_a", rd_addr_a, 12);
            checkOutput("l1j3_b", rd_addr_b, 14);
            checkOutput("l1j3_tw", twiddle_addr, 0);
          end
          if (rd_seen == 3 * HALF + 5) begin
            checkOutput("l3j5_a", rd_addr_a, 17);
            checkOutput("l3j5_b", rd_addr_b, 25);
            checkOutput("l3j5_tw", twiddle_addr, 4);
          end
          rd_seen++;
          idle_run = 0;
        end else if (busy) begin
          idle_run++;
        end

        if (wr_en || en_hist[BF_LAT-1]) checkOutput("wr_en_delay", wr_en, en_hist[BF_LAT-1]);
        if (wr_en) begin
          if (q_wr.size() == 0) checkOutput("wr_unexpected", 1, 0);
          else begin
            e = q_wr.pop_front();
            checkOutput("wr_bank", wr_bank, e.bank);
            checkOutput("wr_addr_a", wr_addr_a, e.a);
            checkOutput("wr_addr_b", wr_addr_b, e.b);
          end
          wr_seen++;
        end
        for (int i = BF_LAT - 1; i > 0; i--) en_hist[i] = en_hist[i-1];
        en_hist[0] = rd_en;

        if (out_valid) begin
          if (prev_ov && !prev_or) checkOutput("out_hold", out_addr, prev_oa);
          checkOutput("out_bank", out_bank, LOG2N % 2);
          if (out_ready) begin
            if (q_out.size() == 0) checkOutput("out_unexpected", 1, 0);
            else checkOutput("out_addr", out_addr, q_out.pop_front());
          end
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_oa = out_addr;
        if (done) done_seen++;
      end
    end
  end

  // Abort a transform at level 2, j=5 and confirm nothing keeps strobing.
  task automatic resetMidProc();
    int cyc = 0;
    resetScoreboard();
    pushExpected();
    in_valid = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (rd_seen < 2 * HALF + 5 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 2000) checkOutput("t1_timeout", 0, 1);
    checkOutput("t1_l2j5_a", rd_addr_a, 40);
    checkOutput("t1_l2j5_b", rd_addr_b, 44);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_rd_en", rd_en, 0);
    checkOutput("t1_wr_en", wr_en, 0);
    resetScoreboard();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (BF_LAT + 2) begin
      @(posedge clk); #1;
      checkOutput("t1_wr_quiet", wr_en, 0);
      checkOutput("t1_idle", busy, 0);
    end
  endtask

  // One full transform; vmode 0 = in_valid always, 1 = random; rmode 0 = ready always, 1 = 1,0,0,1, 2 = random.
  task automatic applyStimulus(input int vmode, input int rmode, input bit poke_start, input bit chk_latency);
    int cyc = 0;
    bit got_done = 0;
    resetScoreboard();
    pushExpected();
    in_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got_done && cyc < 20000) begin
      in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = poke_start && (cyc == 7 || cyc == 150 || cyc == 400);
      @(posedge clk); #1;
      cyc++;
      if (done) got_done = 1;
    end
    start = 1'b0;
    if (!got_done) checkOutput("done_timeout", 0, 1);
    if (chk_latency) checkOutput("latency", cyc, 338);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("done_width", done, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("done_pulses", done_seen, 1);
    checkOutput("rd_left", q_rd.size(), 0);
    checkOutput("wr_left", q_wr.size(), 0);
    checkOutput("load_left", q_load.size(), 0);
    checkOutput("out_left", q_out.size(), 0);
  endtask

  initial begin
    resetScoreboard();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_addr_a", rd_addr_a, 0);
    checkOutput("rst_wr_addr_b", wr_addr_b, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    resetMidProc();
    applyStimulus(0, 0, 1'b0, 1'b1);
    applyStimulus(0, 1, 1'b0, 1'b0);
    applyStimulus(1, 2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
